// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer scanout controller.
package fb_pkg;

   localparam int BC_W = 7;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_SPACE,
      DRAIN
   } scan_state_t;

endpackage

// File: rtl/fb_scan_ctrl.sv
// Framebuffer scanout: bursts a frame from memory into the pixel FIFO,
// throttled by a credit count of FIFO space plus words still in flight.
module fb_scan_ctrl
   import fb_pkg::*;
#(
   parameter int ADDR_W      = 30,
   parameter int BURST_LEN   = 16,
   parameter int FRAME_WORDS = 384000,
   parameter int FIFO_DEPTH  = 1024
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [ADDR_W-1:0]           start_address,
   input  logic                        enable,
   input  logic                        frame_start,
   output logic [ADDR_W-1:0]           avm_address,
   output logic                        avm_read,
   output logic [BC_W-1:0]             avm_burstcount,
   input  logic                        avm_waitrequest,
   input  logic                        avm_readdatavalid,
   input  logic [31:0]                 avm_readdata,
   output logic                        fifo_wrreq,
   output logic [31:0]                 fifo_data,
   input  logic [$clog2(FIFO_DEPTH):0] fifo_usedw,
   output logic                        busy,
   output logic                        overrun
);

   localparam int UW  = $clog2(FIFO_DEPTH) + 1;
   localparam int FWW = $clog2(FRAME_WORDS + 1);
   localparam int WLW = (FWW > BC_W) ? FWW : BC_W;
   localparam int CW  = ((UW > BC_W) ? UW : BC_W) + 2;

   scan_state_t       state;
   logic [ADDR_W-1:0] cur_addr;
   logic [WLW-1:0]    words_left;
   logic [UW-1:0]     pending;
   logic [BC_W-1:0]   bc;
   logic              accept;
   logic              ret;
   logic              credit_ok;
   logic [WLW-1:0]    words_after;
   logic [UW-1:0]     pending_nx;

   always_comb begin
      bc = '0;
      if (words_left >= WLW'(BURST_LEN))
         bc = BC_W'(BURST_LEN);
      else
         bc = BC_W'(words_left);
      accept = avm_read & ~avm_waitrequest;
      // returns after a reset are strays from dropped bursts
      ret = avm_readdatavalid & (pending != '0);
      credit_ok = (CW'(fifo_usedw) + CW'(pending) + CW'(bc))
                  <= CW'(FIFO_DEPTH);
      words_after = words_left - WLW'(avm_burstcount);
      pending_nx = pending;
      if (accept)
         pending_nx = pending_nx + UW'(avm_burstcount);
      if (ret)
         pending_nx = pending_nx - UW'(1);
   end

   assign fifo_wrreq = ret;
   assign fifo_data  = ret ? avm_readdata : 32'h0;
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         cur_addr       <= '0;
         words_left     <= '0;
         pending        <= '0;
         avm_read       <= 1'b0;
         avm_address    <= '0;
         avm_burstcount <= '0;
         overrun        <= 1'b0;
      end else begin
         pending <= pending_nx;
         if (frame_start && state != IDLE)
            overrun <= 1'b1;
         unique case (state)
            IDLE: begin
               if (enable && frame_start) begin
                  cur_addr   <= start_address & ~ADDR_W'(3);
                  words_left <= WLW'(FRAME_WORDS);
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (avm_read) begin
                  if (accept) begin
                     avm_read   <= 1'b0;
                     cur_addr   <= cur_addr
                                   + ADDR_W'({avm_burstcount, 2'b00});
                     words_left <= words_after;
                     if (words_after == '0 || !enable)
                        state <= DRAIN;
                  end
               end else if (!enable) begin
                  state <= DRAIN;
               end else if (credit_ok) begin
                  avm_read       <= 1'b1;
                  avm_address    <= cur_addr;
                  avm_burstcount <= bc;
               end else begin
                  state <= WAIT_SPACE;
               end
            end
            WAIT_SPACE: begin
               if (!enable)
                  state <= DRAIN;
               else if (credit_ok)
                  state <= ISSUE;
            end
            DRAIN: begin
               if (pending == '0)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
